// File: rtl/rv_iopmp_entry_scanner.sv
// IOPMP entry scanner: walks a memory-domain entry range [start, end) and reports the first matching entry.
// Optional performance counters are enabled by defining RV_IOPMP_SCAN_PERF_EN.

package rv_iopmp_pkg;
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_TOR   = 2'd1,
        MODE_NA4   = 2'd2,
        MODE_NAPOT = 2'd3
    } mode_t;
endpackage

// Single-entry address matcher. Entry addresses are word addresses (byte address >> 2).
module rv_iopmp_entry #(
    parameter int LEN        = 32,
    parameter int ADDR_WIDTH = 64,
    parameter int NB_WIDTH   = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [NB_WIDTH-1:0]   num_bytes_i,
    input  rv_iopmp_pkg::mode_t   mode_i,
    input  logic [2*LEN-1:0]      entry_addr_i,
    input  logic [2*LEN-1:0]      prev_addr_i,
    output logic                  match_o,
    output logic                  allow_o
);
    import rv_iopmp_pkg::*;

    // Headroom for the <<2 byte conversion plus NAPOT size/limit carries.
    localparam int CW = ((2*LEN > ADDR_WIDTH) ? 2*LEN : ADDR_WIDTH) + 4;

    logic [CW-1:0] w_req_lo;
    logic [CW-1:0] w_req_hi;
    logic [CW-1:0] w_cur;
    logic [CW-1:0] w_prev;
    logic [CW-1:0] w_napot_mask;
    logic [CW-1:0] w_reg_lo;
    logic [CW-1:0] w_reg_hi;
    logic          w_reg_valid;

    assign w_req_lo     = CW'(addr_i);
    assign w_req_hi     = w_req_lo + CW'(num_bytes_i);
    assign w_cur        = CW'(entry_addr_i);
    assign w_prev       = CW'(prev_addr_i);
    // Trailing ones plus the first zero above them select the NAPOT size.
    assign w_napot_mask = w_cur ^ (w_cur + CW'(1));

    always_comb begin
        w_reg_lo    = '0;
        w_reg_hi    = '0;
        w_reg_valid = 1'b0;
        case (mode_i)
            MODE_TOR: begin
                w_reg_lo    = w_prev << 2;
                w_reg_hi    = w_cur << 2;
                w_reg_valid = 1'b1;
            end
            MODE_NA4: begin
                w_reg_lo    = w_cur << 2;
                w_reg_hi    = (w_cur << 2) + CW'(4);
                w_reg_valid = 1'b1;
            end
            MODE_NAPOT: begin
                w_reg_lo    = (w_cur & ~w_napot_mask) << 2;
                w_reg_hi    = ((w_cur & ~w_napot_mask) << 2) + ((w_napot_mask + CW'(1)) << 2);
                w_reg_valid = 1'b1;
            end
            default: begin
                w_reg_valid = 1'b0;
            end
        endcase
    end

    // Any byte overlapping the region is a hit; allow only when every byte lies inside.
    assign match_o = w_reg_valid
                   && (w_reg_lo < w_reg_hi)
                   && (w_req_lo < w_req_hi)
                   && (w_req_lo < w_reg_hi)
                   && (w_reg_lo < w_req_hi);
    assign allow_o = match_o && (w_req_lo >= w_reg_lo) && (w_req_hi <= w_reg_hi);
endmodule

module rv_iopmp_entry_scanner #(
    parameter int NUM_ENTRIES = 16,
    parameter int LEN         = 32,
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [ADDR_WIDTH-1:0]            req_addr_i,
    input  logic [$clog2(DATA_WIDTH/8):0]    req_num_bytes_i,
    input  logic                             req_write_i,
    input  logic [$clog2(NUM_ENTRIES):0]     req_start_idx_i,
    input  logic [$clog2(NUM_ENTRIES):0]     req_end_idx_i,
    output logic                             entry_rd_o,
    output logic [$clog2(NUM_ENTRIES)-1:0]   entry_idx_o,
    input  logic [LEN-1:0]                   entry_addr_i,
    input  logic [LEN-1:0]                   entry_addrh_i,
    input  rv_iopmp_pkg::mode_t              entry_mode_i,
    input  logic                             entry_r_i,
    input  logic                             entry_w_i,
    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic                             rsp_allow_o,
    output logic [1:0]                       rsp_err_o,
    output logic [$clog2(NUM_ENTRIES)-1:0]   rsp_entry_idx_o,
    output logic [31:0]                      perf_scans_o,
    output logic [31:0]                      perf_cycles_o
);
    localparam int IW  = $clog2(NUM_ENTRIES);
    localparam int RW  = IW + 1;
    localparam int NBW = $clog2(DATA_WIDTH/8) + 1;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_NOHIT   = 2'd1;
    localparam logic [1:0] ERR_PARTIAL = 2'd2;
    localparam logic [1:0] ERR_PERM    = 2'd3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRIME      = 3'd1,
        PRIME_WAIT = 3'd2,
        FETCH      = 3'd3,
        CHECK      = 3'd4,
        RESP       = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [NBW-1:0]        r_num_bytes;
    logic                  r_write;
    logic [IW-1:0]         r_idx;
    logic [RW-1:0]         r_end;
    logic [2*LEN-1:0]      r_prev;
    logic                  r_rsp_allow;
    logic [1:0]            r_rsp_err;
    logic [IW-1:0]         r_rsp_idx;

    logic [RW-1:0]         w_end_clamped;
    logic                  w_match;
    logic                  w_allow;
    logic                  w_perm;
    logic                  w_last;
    logic                  w_accept;
    logic                  w_clear_prev;
    logic                  w_load_prev;
    logic                  w_idx_inc;
    logic                  w_rsp_load;
    logic                  w_rsp_allow_next;
    logic [1:0]            w_rsp_err_next;
    logic [IW-1:0]         w_rsp_idx_next;
    logic                  w_entry_rd;
    logic [IW-1:0]         w_entry_idx;

    assign w_end_clamped = (req_end_idx_i > RW'(NUM_ENTRIES)) ? RW'(NUM_ENTRIES) : req_end_idx_i;
    assign w_perm        = r_write ? entry_w_i : entry_r_i;
    assign w_last        = (({1'b0, r_idx} + RW'(1)) == r_end);

    rv_iopmp_entry #(
        .LEN        (LEN),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NB_WIDTH   (NBW)
    ) u_entry (
        .addr_i       (r_addr),
        .num_bytes_i  (r_num_bytes),
        .mode_i       (entry_mode_i),
        .entry_addr_i ({entry_addrh_i, entry_addr_i}),
        .prev_addr_i  (r_prev),
        .match_o      (w_match),
        .allow_o      (w_allow)
    );

    always_comb begin
        w_state_next     = r_state;
        w_accept         = 1'b0;
        w_clear_prev     = 1'b0;
        w_load_prev      = 1'b0;
        w_idx_inc        = 1'b0;
        w_rsp_load       = 1'b0;
        w_rsp_allow_next = 1'b0;
        w_rsp_err_next   = ERR_NONE;
        w_rsp_idx_next   = '0;
        w_entry_rd       = 1'b0;
        w_entry_idx      = '0;
        case (r_state)
            IDLE: begin
                if (req_valid_i) begin
                    w_accept = 1'b1;
                    if (req_start_idx_i >= w_end_clamped) begin
                        w_rsp_load     = 1'b1;
                        w_rsp_err_next = ERR_NOHIT;
                        w_state_next   = RESP;
                    end else if (req_start_idx_i != '0) begin
                        w_state_next = PRIME;
                    end else begin
                        w_clear_prev = 1'b1;
                        w_state_next = FETCH;
                    end
                end
            end
            PRIME: begin
                // The entry below the range supplies the TOR base of the first entry.
                w_entry_rd   = 1'b1;
                w_entry_idx  = r_idx - IW'(1);
                w_state_next = PRIME_WAIT;
            end
            PRIME_WAIT: begin
                w_load_prev  = 1'b1;
                w_state_next = FETCH;
            end
            FETCH: begin
                w_entry_rd   = 1'b1;
                w_entry_idx  = r_idx;
                w_state_next = CHECK;
            end
            CHECK: begin
                w_rsp_idx_next = r_idx;
                if (w_match) begin
                    w_rsp_load   = 1'b1;
                    w_state_next = RESP;
                    if (!w_allow) begin
                        w_rsp_err_next = ERR_PARTIAL;
                    end else if (!w_perm) begin
                        w_rsp_err_next = ERR_PERM;
                    end else begin
                        w_rsp_err_next   = ERR_NONE;
                        w_rsp_allow_next = 1'b1;
                    end
                end else begin
                    w_load_prev = 1'b1;
                    if (w_last) begin
                        w_rsp_load     = 1'b1;
                        w_rsp_err_next = ERR_NOHIT;
                        w_state_next   = RESP;
                    end else begin
                        w_idx_inc    = 1'b1;
                        w_state_next = FETCH;
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_num_bytes <= '0;
            r_write     <= 1'b0;
            r_idx       <= '0;
            r_end       <= '0;
            r_prev      <= '0;
            r_rsp_allow <= 1'b0;
            r_rsp_err   <= ERR_NONE;
            r_rsp_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr      <= req_addr_i;
                r_num_bytes <= req_num_bytes_i;
                r_write     <= req_write_i;
                r_idx       <= req_start_idx_i[IW-1:0];
                r_end       <= w_end_clamped;
            end
            if (w_clear_prev) begin
                r_prev <= '0;
            end else if (w_load_prev) begin
                r_prev <= {entry_addrh_i, entry_addr_i};
            end
            if (w_idx_inc) begin
                r_idx <= r_idx + IW'(1);
            end
            if (w_rsp_load) begin
                r_rsp_allow <= w_rsp_allow_next;
                r_rsp_err   <= w_rsp_err_next;
                r_rsp_idx   <= w_rsp_idx_next;
            end
        end
    end

    assign req_ready_o     = (r_state == IDLE);
    assign rsp_valid_o     = (r_state == RESP);
    assign rsp_allow_o     = r_rsp_allow;
    assign rsp_err_o       = r_rsp_err;
    assign rsp_entry_idx_o = r_rsp_idx;
    assign entry_rd_o      = w_entry_rd;
    assign entry_idx_o     = w_entry_idx;

`ifdef RV_IOPMP_SCAN_PERF_EN
    // Counter 0: response handshakes; counter 1: cycles spent outside IDLE. Both saturate.
    logic [1:0]  w_perf_inc;
    logic [31:0] w_perf_val [2];

    assign w_perf_inc[0] = (r_state == RESP) && rsp_ready_i;
    assign w_perf_inc[1] = (r_state != IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            logic [31:0] r_cnt;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_cnt <= '0;
                end else if (w_perf_inc[gi] && (r_cnt != 32'hFFFF_FFFF)) begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
            assign w_perf_val[gi] = r_cnt;
        end
    endgenerate

    assign perf_scans_o  = w_perf_val[0];
    assign perf_cycles_o = w_perf_val[1];
`else
    assign perf_scans_o  = 32'd0;
    assign perf_cycles_o = 32'd0;
`endif
endmodule

// File: doc/rv_iopmp_entry_scanner.md
RV_IOPMP_ENTRY_SCANNER -- requirements
Module: rv_iopmp_entry_scanner

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 16, number of entries in the table (power of 2, at least 2).
REQ-002 SHALL have parameter LEN, default 32, width of each entry address word.
REQ-003 SHALL have parameter ADDR_WIDTH, default 64, request address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 64, bus data width; it sizes num_bytes_i.
REQ-005 SHALL have ports, clock and reset first: clk_i in 1 clock; rst_i in 1 reset, synchronous, active-high.
REQ-006 SHALL have ports req_valid_i in 1, req_ready_o out 1: request handshake.
REQ-007 SHALL have ports req_addr_i in ADDR_WIDTH, req_num_bytes_i in $clog2(DATA_WIDTH/8)+1, req_write_i in 1 (1 = write, 0 = read).
REQ-008 SHALL have ports req_start_idx_i, req_end_idx_i, each in $clog2(NUM_ENTRIES)+1: memory-domain entry range [start, end).
REQ-009 SHALL have ports entry_rd_o out 1, entry_idx_o out $clog2(NUM_ENTRIES): entry-table read port.
REQ-010 SHALL have ports entry_addr_i, entry_addrh_i in LEN each; entry_mode_i in rv_iopmp_pkg::mode_t; entry_r_i, entry_w_i in 1 each. Read data is valid exactly one cycle after entry_rd_o.
REQ-011 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1: response handshake.
REQ-012 SHALL have ports rsp_allow_o out 1; rsp_err_o out 2 (0 none, 1 no-hit, 2 partial, 3 permission); rsp_entry_idx_o out $clog2(NUM_ENTRIES).

Function
REQ-013 SHALL use an FSM with states IDLE, PRIME, PRIME_WAIT, FETCH, CHECK, RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-014 On a handshake in IDLE, the block SHALL latch the request and clamp end to NUM_ENTRIES. If start >= clamped end, go to RESP with err 1; else if start > 0, go to PRIME; else clear the prev-address register to 0 and go to FETCH.
REQ-015 PRIME SHALL drive entry_rd_o=1 with idx start-1. PRIME_WAIT SHALL load the returned {addrh, addr} into the prev-address register, then go to FETCH.
REQ-016 FETCH SHALL drive entry_rd_o=1 with the current idx. CHECK SHALL evaluate the returned entry via an internal rv_iopmp_entry instance, using the prev-address register as the previous entry.
REQ-017 In CHECK, on match_o=1, the scan SHALL stop and go to RESP with rsp_entry_idx_o set to the current idx:
- allow_o=0 -> err 2, rsp_allow_o=0
- permission bit for the access type (entry_w_i for write, entry_r_i for read) = 0 -> err 3, rsp_allow_o=0
- otherwise -> err 0, rsp_allow_o=1
REQ-018 In CHECK with no match, the block SHALL load the entry address into prev-address and increment idx. When idx+1 equals the clamped end, go to RESP with err 1 and rsp_entry_idx_o set to the last idx checked; otherwise return to FETCH.
REQ-019 OFF-mode entries SHALL never match but SHALL still update prev-address.
REQ-020 Each checked entry SHALL cost 2 cycles. Start=0, match at entry k: rsp_valid_o asserts k*2+3 cycles after the request handshake cycle. Start>0 adds 2 cycles.
REQ-021 RESP SHALL hold rsp_valid_o and all rsp fields stable until rsp_ready_i, then go to IDLE. A new request SHALL NOT be accepted in the same cycle.
REQ-022 entry_rd_o SHALL be 0 in every state other than PRIME and FETCH.
REQ-023 Request inputs SHALL be sampled only at the handshake; changes during a scan SHALL be ignored.

Reset
REQ-024 rst_i high at a clock edge SHALL force IDLE and abandon any scan. All outputs SHALL be 0 except req_ready_o=1 on the following cycle. Prev-address and perf counters SHALL be cleared.

Configuration
REQ-025 Macro RV_IOPMP_SCAN_PERF_EN defined SHALL add outputs perf_scans_o (32 bits, +1 per response handshake) and perf_cycles_o (32 bits, +1 per cycle not in IDLE). Both SHALL saturate at all-ones.
REQ-026 Without RV_IOPMP_SCAN_PERF_EN, the ports SHALL still exist, SHALL be tied to 0, and no counter logic SHALL be synthesized.

Verification
REQ-027 Entry0 TOR addr=0x400 (limit 0x1000), r=1; read 0x800, 8 bytes, range [0,4) -> allow=1, err=0, idx=0, rsp_valid 3 cycles after accept.
REQ-028 Entry2 NAPOT covering 0x2000-0x2FFF, w=0; write 0x2100, range [0,4) -> allow=0, err=3, idx=2, latency 7.
REQ-029 Entry1 TOR with entry0 addr=0x400, entry1 addr=0x800 (range 0x1000-0x1FFF); read 0x1FFC, 8 bytes, range [1,3) -> PRIME reads idx 0, err=2, idx=1.
REQ-030 No entry matches 0xDEAD0000, range [0,16) -> err=1, idx=15, 16 FETCH reads issued, latency 33.
REQ-031 Range [5,5), then a second test with end=20 on a 16-entry table: first gives err=1 with no entry reads; second scans only to idx 15.
REQ-032 rst_i asserted during FETCH of idx 3, and rsp_ready_i held 0 for 5 cycles in RESP -> reset returns to idle state with outputs zero; the held response stays stable, and perf counters match cycle counts when the macro is defined.
